// File: rtl/photo_target_game.sv
// Two-player laser target controller: synchronised flex triggers fire the lasers, and debounced
// photo sensors register hits on each player's lit target. Scores are BCD and shown on 7-seg digits.
module photo_target_game #(
  parameter int unsigned N_PHOTO        = 10,
  parameter int unsigned DEB_CYCLES     = 500_000,
  parameter int unsigned FIRE_CYCLES    = 25_000_000,
  parameter int unsigned COOL_CYCLES    = 50_000_000,
  parameter int unsigned TARGET_TIMEOUT = 250_000_000,
  localparam int unsigned TGT_W         = $clog2(N_PHOTO)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flex_l,
  input  logic               flex_r,
  input  logic [N_PHOTO-1:0] photo_array,
  output logic               laser_l,
  output logic               laser_r,
  output logic [TGT_W-1:0]   target_a,
  output logic [TGT_W-1:0]   target_b,
  output logic [6:0]         score_digit_a,
  output logic [6:0]         score_digit_b,
  output logic [6:0]         score_digit_c,
  output logic [6:0]         score_digit_d
);

  localparam int unsigned DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int unsigned TMR_MAX = (FIRE_CYCLES > COOL_CYCLES) ? FIRE_CYCLES : COOL_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned TO_W    = $clog2(TARGET_TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FIRE, ST_COOL} laser_st_t;

  logic [1:0]         r_flex_l_sync, r_flex_r_sync;
  logic [1:0]         r_flex_d;
  logic [N_PHOTO-1:0] r_photo_s1, r_photo_s2, r_deb, r_deb_d;
  logic [DEB_W-1:0]   r_deb_cnt [N_PHOTO];
  laser_st_t          r_st [2];
  laser_st_t          w_st_nxt [2];
  logic [1:0][TMR_W-1:0] r_tmr, w_tmr_nxt;
  logic [1:0]         r_laser, w_laser_nxt;
  logic [1:0]         w_flex_sync, w_flex_rise, w_hit;
  logic [N_PHOTO-1:0] w_rise;
  logic [7:0]         r_lfsr;
  logic [TGT_W-1:0]   r_tgt_a, r_tgt_b, w_v, w_new_a, w_new_b;
  logic [TO_W-1:0]    r_to_a, r_to_b;
  logic               w_re_a, w_re_b;
  logic [1:0][7:0]    r_score;
  logic [6:0]         r_dig_a, r_dig_b, r_dig_c, r_dig_d;

  function automatic logic [TGT_W-1:0] f_inc(input logic [TGT_W-1:0] v);
    f_inc = (v == TGT_W'(N_PHOTO - 1)) ? '0 : v + TGT_W'(1);
  endfunction

  // First of v, v+1, v+2 (mod N_PHOTO) that clashes with neither target
  function automatic logic [TGT_W-1:0] f_pick(input logic [TGT_W-1:0] v,
                                               input logic [TGT_W-1:0] other,
                                               input logic [TGT_W-1:0] own);
    logic [TGT_W-1:0] c1, c2;
    c1 = f_inc(v);
    c2 = f_inc(c1);
    if (v != other && v != own)        f_pick = v;
    else if (c1 != other && c1 != own) f_pick = c1;
    else if (c2 != other && c2 != own) f_pick = c2;
    else if (v != other)               f_pick = v;
    else                               f_pick = c1;
  endfunction

  function automatic logic [7:0] f_bcd_inc(input logic [7:0] bcd);
    if (bcd == 8'h99)             f_bcd_inc = bcd;
    else if (bcd[3:0] == 4'd9)    f_bcd_inc = {bcd[7:4] + 4'd1, 4'd0};
    else                          f_bcd_inc = {bcd[7:4], bcd[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'b1000000;
      4'd1:    f_seg = 7'b1111001;
      4'd2:    f_seg = 7'b0100100;
      4'd3:    f_seg = 7'b0110000;
      4'd4:    f_seg = 7'b0011001;
      4'd5:    f_seg = 7'b0010010;
      4'd6:    f_seg = 7'b0000010;
      4'd7:    f_seg = 7'b1111000;
      4'd8:    f_seg = 7'b0000000;
      4'd9:    f_seg = 7'b0010000;
      default: f_seg = 7'b1111111;
    endcase
  endfunction

  // Input synchronisers and per-channel debounce
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_flex_l_sync <= '0;
      r_flex_r_sync <= '0;
      r_flex_d      <= '0;
      r_photo_s1    <= '0;
      r_photo_s2    <= '0;
      r_deb         <= '0;
      r_deb_d       <= '0;
      for (int i = 0; i < N_PHOTO; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_flex_l_sync <= {r_flex_l_sync[0], flex_l};
      r_flex_r_sync <= {r_flex_r_sync[0], flex_r};
      r_flex_d      <= w_flex_sync;
      r_photo_s1    <= photo_array;
      r_photo_s2    <= r_photo_s1;
      r_deb_d       <= r_deb;
      for (int i = 0; i < N_PHOTO; i++) begin
        if (r_photo_s2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          r_deb[i]     <= r_photo_s2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  assign w_flex_sync = {r_flex_r_sync[1], r_flex_l_sync[1]};
  assign w_flex_rise = w_flex_sync & ~r_flex_d;
  assign w_rise      = r_deb & ~r_deb_d;
  assign w_hit[0]    = (r_st[0] == ST_FIRE) && w_rise[r_tgt_a];
  assign w_hit[1]    = (r_st[1] == ST_FIRE) && w_rise[r_tgt_b];

  // Laser FSMs: index 0 = left, 1 = right
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < 2; s++) r_st[s] <= ST_IDLE;
      r_tmr   <= '0;
      r_laser <= '0;
    end else begin
      for (int s = 0; s < 2; s++) r_st[s] <= w_st_nxt[s];
      r_tmr   <= w_tmr_nxt;
      r_laser <= w_laser_nxt;
    end
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_st_nxt[s]  = r_st[s];
      w_tmr_nxt[s] = r_tmr[s] + TMR_W'(1);
      case (r_st[s])
        ST_IDLE: begin
          w_tmr_nxt[s] = '0;
          if (w_flex_rise[s]) w_st_nxt[s] = ST_FIRE;
        end
        ST_FIRE: begin
          if (w_hit[s] || r_tmr[s] == TMR_W'(FIRE_CYCLES - 1)) begin
            w_st_nxt[s]  = ST_COOL;
            w_tmr_nxt[s] = '0;
          end
        end
        ST_COOL: begin
          if (r_tmr[s] == TMR_W'(COOL_CYCLES - 1)) begin
            w_st_nxt[s]  = ST_IDLE;
            w_tmr_nxt[s] = '0;
          end
        end
        default: begin
          w_st_nxt[s]  = ST_IDLE;
          w_tmr_nxt[s] = '0;
        end
      endcase
      w_laser_nxt[s] = (w_st_nxt[s] == ST_FIRE);
    end
  end

  // Target reassignment: left resolves first, right avoids left's new value
  assign w_re_a  = w_hit[0] || (r_to_a == TO_W'(TARGET_TIMEOUT - 1));
  assign w_re_b  = w_hit[1] || (r_to_b == TO_W'(TARGET_TIMEOUT - 1));
  assign w_v     = TGT_W'(r_lfsr % 8'(N_PHOTO));
  assign w_new_a = w_re_a ? f_pick(w_v, r_tgt_b, r_tgt_a) : r_tgt_a;
  assign w_new_b = w_re_b ? f_pick(w_v, w_new_a, r_tgt_b) : r_tgt_b;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lfsr  <= 8'h01;
      r_tgt_a <= TGT_W'(0);
      r_tgt_b <= TGT_W'(1);
      r_to_a  <= '0;
      r_to_b  <= '0;
      r_score <= '0;
      r_dig_a <= 7'b1000000;
      r_dig_b <= 7'b1000000;
      r_dig_c <= 7'b1000000;
      r_dig_d <= 7'b1000000;
    end else begin
      r_lfsr  <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      r_tgt_a <= w_new_a;
      r_tgt_b <= w_new_b;
      r_to_a  <= w_re_a ? '0 : r_to_a + TO_W'(1);
      r_to_b  <= w_re_b ? '0 : r_to_b + TO_W'(1);
      for (int s = 0; s < 2; s++) begin
        if (w_hit[s]) r_score[s] <= f_bcd_inc(r_score[s]);
      end
      r_dig_a <= f_seg(r_score[0][7:4]);
      r_dig_b <= f_seg(r_score[0][3:0]);
      r_dig_c <= f_seg(r_score[1][7:4]);
      r_dig_d <= f_seg(r_score[1][3:0]);
    end
  end

  assign laser_l       = r_laser[0];
  assign laser_r       = r_laser[1];
  assign target_a      = r_tgt_a;
  assign target_b      = r_tgt_b;
  assign score_digit_a = r_dig_a;
  assign score_digit_b = r_dig_b;
  assign score_digit_c = r_dig_c;
  assign score_digit_d = r_dig_d;

endmodule

// File: tb/tb_photo_target_game.sv
// Directed bench for photo_target_game: reset, shot timing, hits, bounce rejection,
// BCD rollover/saturation, target timeout and asynchronous reset mid-shot.
module tb_photo_target_game;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flex_l = 1'b0;
  logic       flex_r = 1'b0;
  logic [9:0] photo = '0;
  logic       laser_l, laser_r;
  logic [3:0] target_a, target_b;
  logic [6:0] dig_a, dig_b, dig_c, dig_d;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  photo_target_game #(
    .N_PHOTO(10), .DEB_CYCLES(4), .FIRE_CYCLES(20), .COOL_CYCLES(10), .TARGET_TIMEOUT(200)
  ) dut (
    .clock(clk), .reset(rst_n), .flex_l(flex_l), .flex_r(flex_r), .photo_array(photo),
    .laser_l(laser_l), .laser_r(laser_r), .target_a(target_a), .target_b(target_b),
    .score_digit_a(dig_a), .score_digit_b(dig_b), .score_digit_c(dig_c), .score_digit_d(dig_d)
  );

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'b1000000;
      1: seg = 7'b1111001;
      2: seg = 7'b0100100;
      3: seg = 7'b0110000;
      4: seg = 7'b0011001;
      5: seg = 7'b0010010;
      6: seg = 7'b0000010;
      7: seg = 7'b1111000;
      8: seg = 7'b0000000;
      default: seg = 7'b0010000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Raise a trigger and return at the first negedge where its laser is on
  task automatic shoot(input int side);
    logic seen;
    seen = 1'b0;
    if (side == 0) flex_l = 1'b1; else flex_r = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((side == 0) ? laser_l : laser_r) begin
        seen = 1'b1;
        break;
      end
    end
    if (side == 0) flex_l = 1'b0; else flex_r = 1'b0;
    chk("laser_on", 32'(seen), 32'd1);
  endtask

  // Shoot, light the current target for 10 cycles, report whether the laser was cut short
  task automatic hit(input int side, output logic dropped);
    int tgt;
    shoot(side);
    tgt = (side == 0) ? int'(target_a) : int'(target_b);
    photo[tgt] = 1'b1;
    repeat (10) @(negedge clk);
    photo[tgt] = 1'b0;
    dropped = !((side == 0) ? laser_l : laser_r);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    int   exp_score;
    int   ch;
    int   tgt;
    logic dropped;
    logic [3:0] t_saved;

    // 1: reset values, held after release
    repeat (3) @(negedge clk);
    chk("rst_laser_l", 32'(laser_l), 32'd0);
    chk("rst_laser_r", 32'(laser_r), 32'd0);
    chk("rst_tgt_a", 32'(target_a), 32'd0);
    chk("rst_tgt_b", 32'(target_b), 32'd1);
    chk("rst_dig_a", 32'(dig_a), 32'(7'b1000000));
    chk("rst_dig_b", 32'(dig_b), 32'(7'b1000000));
    chk("rst_dig_c", 32'(dig_c), 32'(7'b1000000));
    chk("rst_dig_d", 32'(dig_d), 32'(7'b1000000));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rel_tgt_a", 32'(target_a), 32'd0);
    chk("rel_tgt_b", 32'(target_b), 32'd1);
    chk("rel_dig_b", 32'(dig_b), 32'(7'b1000000));

    // 2: shot length, edge during cooldown ignored, held trigger does not refire
    flex_l = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (laser_l) begin
        cnt = 1;
        break;
      end
    end
    for (int i = 0; i < 40 && cnt > 0; i++) begin
      @(negedge clk);
      if (laser_l) cnt++; else break;
    end
    chk("fire_len", 32'(cnt), 32'd20);
    flex_l = 1'b0;
    repeat (3) @(negedge clk);
    flex_l = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (laser_l) cnt++;
    end
    chk("cool_ignore", 32'(cnt), 32'd0);
    flex_l = 1'b0;
    repeat (5) @(negedge clk);

    // 3: single left hit, then a right hit
    do_reset();
    hit(0, dropped);
    chk("hit1_drop", 32'(dropped), 32'd1);
    chk("hit1_dig_a", 32'(dig_a), 32'(seg(0)));
    chk("hit1_dig_b", 32'(dig_b), 32'(7'b1111001));
    chk("hit1_ne", 32'(target_a != target_b), 32'd1);
    hit(1, dropped);
    chk("hitr_drop", 32'(dropped), 32'd1);
    chk("hitr_dig_c", 32'(dig_c), 32'(seg(0)));
    chk("hitr_dig_d", 32'(dig_d), 32'(seg(1)));
    chk("hitr_dig_b", 32'(dig_b), 32'(seg(1)));

    // 4: bouncing target input and a rise on a non-target channel score nothing
    shoot(0);
    tgt = int'(target_a);
    for (int i = 0; i < 8; i++) begin
      photo[tgt] = ~photo[tgt];
      repeat (2) @(negedge clk);
    end
    chk("bounce_laser", 32'(laser_l), 32'd1);
    repeat (20) @(negedge clk);
    chk("bounce_dig_b", 32'(dig_b), 32'(seg(1)));
    shoot(0);
    ch = (int'(target_a) + 1) % 10;
    photo[ch] = 1'b1;
    repeat (10) @(negedge clk);
    chk("other_laser", 32'(laser_l), 32'd1);
    photo[ch] = 1'b0;
    repeat (25) @(negedge clk);
    chk("other_dig_a", 32'(dig_a), 32'(seg(0)));
    chk("other_dig_b", 32'(dig_b), 32'(seg(1)));

    // 5: hits 2..100 through the 9->10 rollover and saturation at 99
    for (int k = 2; k <= 100; k++) begin
      hit(0, dropped);
      exp_score = (k > 99) ? 99 : k;
      chk("sat_drop", 32'(dropped), 32'd1);
      chk("sat_dig_a", 32'(dig_a), 32'(seg(exp_score / 10)));
      chk("sat_dig_b", 32'(dig_b), 32'(seg(exp_score % 10)));
      chk("sat_ne", 32'(target_a != target_b), 32'd1);
    end
    chk("sat99_a", 32'(dig_a), 32'(7'b0010000));
    chk("sat99_b", 32'(dig_b), 32'(7'b0010000));
    chk("sat_dig_d", 32'(dig_d), 32'(seg(1)));

    // 6: timeout reassigns without scoring; async reset mid-shot
    t_saved = target_a;
    repeat (150) @(negedge clk);
    chk("to_hold", 32'(target_a), 32'(t_saved));
    repeat (60) @(negedge clk);
    chk("to_moved", 32'(target_a != t_saved), 32'd1);
    chk("to_ne", 32'(target_a != target_b), 32'd1);
    chk("to_dig_a", 32'(dig_a), 32'(seg(9)));
    chk("to_dig_b", 32'(dig_b), 32'(seg(9)));
    shoot(0);
    repeat (3) @(negedge clk);
    chk("pre_rst_laser", 32'(laser_l), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_laser", 32'(laser_l), 32'd0);
    chk("arst_tgt_a", 32'(target_a), 32'd0);
    chk("arst_tgt_b", 32'(target_b), 32'd1);
    chk("arst_dig_b", 32'(dig_b), 32'(7'b1000000));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_laser", 32'(laser_l), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
